multicycle_alu: RTL

//  Parametrised ALU for the multicycle datapath: single-cycle ADD/SUB/AND/NEG/PASS plus iterative

---
 rtl/multicycle_alu.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// Multicycle-datapath ALU: single-cycle ADD/SUB/AND/NEG/PASSB and
// iterative (one bit per clock) unsigned MUL/DIV/REM behind a start/done handshake.
module multicycle_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_NEG  = 3'd3;
  localparam logic [2:0] OP_PASS = 3'd4;
  localparam logic [2:0] OP_MULU = 3'd5;
  localparam logic [2:0] OP_DIVU = 3'd6;
  localparam logic [2:0] OP_REMU = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nx;

  // acc: product high half / partial remainder; lo: multiplier / quotient
  logic [WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] lo, lo_nx;
  logic [WIDTH-1:0] dvs, dvs_nx;
  logic [2:0]       op_q, op_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic             load;
  logic [WIDTH-1:0] res_nx;
  logic             carry_nx;
  logic             ovf_nx;
  logic             dz_nx;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // Datapath arithmetic shared by both FSM branches
  always_comb begin
    add_sum   = {1'b0, a} + {1'b0, b};
    sub_diff  = {1'b0, a} - {1'b0, b};
    mul_sum   = {1'b0, acc} + {1'b0, dvs & {WIDTH{lo[0]}}};
    div_shift = {acc, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvs};
  end

  // Next-state, iteration step and result/flag selection
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    lo_nx    = lo;
    dvs_nx   = dvs;
    op_nx    = op_q;
    cnt_nx   = cnt;
    load     = 1'b0;
    res_nx   = '0;
    carry_nx = 1'b0;
    ovf_nx   = 1'b0;
    dz_nx    = 1'b0;

    case (state)
      CALC: begin
        cnt_nx = cnt - CNT_W'(1);
        if (op_q == OP_MULU) begin
          acc_nx = mul_sum[WIDTH:1];
          lo_nx  = {mul_sum[0], lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
          acc_nx = div_diff[WIDTH-1:0];
          lo_nx  = {lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_nx = div_shift[WIDTH-1:0];
          lo_nx  = {lo[WIDTH-2:0], 1'b0};
        end
        if (cnt == CNT_W'(1)) begin
          state_nx = FIN;
          load     = 1'b1;
          res_nx   = (op_q == OP_REMU) ? acc_nx : lo_nx;
          ovf_nx   = (op_q == OP_MULU) && (acc_nx != '0);
        end
      end
      default: begin
        // IDLE and FIN both accept a new request
        state_nx = IDLE;
        if (start) begin
          op_nx    = op;
          load     = 1'b1;
          state_nx = FIN;
          case (op)
            OP_ADD: begin
              res_nx   = add_sum[WIDTH-1:0];
              carry_nx = add_sum[WIDTH];
              ovf_nx   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              res_nx   = sub_diff[WIDTH-1:0];
              carry_nx = ~sub_diff[WIDTH];
              ovf_nx   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res_nx = a & b;
            OP_NEG:  res_nx = '0 - b;
            OP_PASS: res_nx = b;
            default: begin
              if ((op != OP_MULU) && (b == '0)) begin
                res_nx = (op == OP_DIVU) ? '1 : a;
                dz_nx  = 1'b1;
              end else begin
                load     = 1'b0;
                state_nx = CALC;
                acc_nx   = '0;
                lo_nx    = a;
                dvs_nx   = b;
                cnt_nx   = CNT_W'(WIDTH);
              end
            end
          endcase
        end
      end
    endcase
  end

  // State, operand and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      lo       <= '0;
      dvs      <= '0;
      op_q     <= '0;
      cnt      <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      lo    <= lo_nx;
      dvs   <= dvs_nx;
      op_q  <= op_nx;
      cnt   <= cnt_nx;
      ready <= (state_nx != CALC);
      done  <= load;
      if (load) begin
        result   <= res_nx;
        zero     <= (res_nx == '0);
        negative <= res_nx[WIDTH-1];
        carry    <= carry_nx;
        overflow <= ovf_nx;
        div_zero <= dz_nx;
      end
    end
  end

endmodule
